// File: rtl/mod_cnt_ctrl.sv
// Run controller for a programmable modulo-N counter: start/pause/stop sequencing,
// per-wrap pulse and completion after a programmable number of wraps.
module mod_cnt_ctrl #(
  parameter int W     = 3,
  parameter int CYC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     modulus,
  input  logic [CYC_W-1:0] n_wraps,
  input  logic             pause,
  input  logic             stop,
  output logic [W-1:0]     q,
  output logic             wrap,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [W-1:0]     mod_r;
  logic [CYC_W-1:0] nw_r;
  logic [CYC_W-1:0] wrap_cnt;

  logic at_last;
  logic budget_hit;
  logic mod_ok;

  // Wrap counter holds at all-ones in free-run so it never rolls back over.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    if (v == {CYC_W{1'b1}}) return v;
    return v + CYC_W'(1);
  endfunction

  assign mod_ok     = (modulus >= W'(2));
  assign at_last    = (q == mod_r - W'(1));
  // nw_r is nonzero here, so nw_r-1 cannot underflow.
  assign budget_hit = (nw_r != '0) && (wrap_cnt == nw_r - CYC_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      q        <= '0;
      wrap     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mod_r    <= '0;
      nw_r     <= '0;
      wrap_cnt <= '0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (mod_ok) begin
              mod_r    <= modulus;
              nw_r     <= n_wraps;
              wrap_cnt <= '0;
              q        <= '0;
              busy     <= 1'b1;
              state    <= S_RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        // PAUSED counts on the same edge that samples pause low, so the
        // count is delayed by exactly the number of edges pause was high.
        S_RUN, S_PAUSED: begin
          if (stop) begin
            q     <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (pause) begin
            state <= S_PAUSED;
          end else begin
            state <= S_RUN;
            if (at_last) begin
              q        <= '0;
              wrap     <= 1'b1;
              wrap_cnt <= sat_inc(wrap_cnt);
              if (budget_hit) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end
            end else begin
              q <= q + W'(1);
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_cnt_ctrl.sv
// Directed bench for mod_cnt_ctrl: counting, wrap budget, pause, stop, err, free-run, async reset.
module tb_mod_cnt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] modulus;
  logic [3:0] n_wraps;
  logic       pause;
  logic       stop;
  logic [2:0] q;
  logic       wrap;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  mod_cnt_ctrl #(.W(3), .CYC_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .modulus (modulus),
    .n_wraps (n_wraps),
    .pause   (pause),
    .stop    (stop),
    .q       (q),
    .wrap    (wrap),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int eq, input int ew, input int eb, input int ed);
    chk({tag, ".q"}, int'(q), eq);
    chk({tag, ".wrap"}, int'(wrap), ew);
    chk({tag, ".busy"}, int'(busy), eb);
    chk({tag, ".done"}, int'(done), ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; modulus = '0; n_wraps = '0; pause = 1'b0; stop = 1'b0;
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0);
    chk("reset.err", int'(err), 0);
    rst = 1'b1;
    tick();

    // 1: modulus 5, two wraps then done
    modulus = 3'd5; n_wraps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("t1.start", 0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) start = 1'b1;
      tick();
      chk_all($sformatf("t1.c%0d", i), i % 5, (i % 5 == 0) ? 1 : 0, (i == 10) ? 0 : 1, (i == 10) ? 1 : 0);
    end
    tick();
    start = 1'b0;
    chk_all("t1.after_done", 0, 0, 0, 0);
    tick();
    chk("t1.idle_busy", int'(busy), 0);

    // 2: free-run modulus 5, pause for 3 edges at q=2
    modulus = 3'd5; n_wraps = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t2.q_before_pause", int'(q), 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("t2.p%0d", i), 2, 0, 1, 0);
    end
    pause = 1'b0;
    tick(); chk_all("t2.r3", 3, 0, 1, 0);
    tick(); chk_all("t2.r4", 4, 0, 1, 0);
    tick(); chk_all("t2.r0", 0, 1, 1, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("t2.stop", 0, 0, 0, 0);

    // 3: stop and pause together at q=3
    modulus = 3'd5; n_wraps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("t3.q3", int'(q), 3);
    stop = 1'b1; pause = 1'b1;
    tick();
    stop = 1'b0; pause = 1'b0;
    chk_all("t3.stop", 0, 0, 0, 0);
    tick();
    chk_all("t3.idle", 0, 0, 0, 0);

    // 4: illegal moduli, then modulus 7 with one wrap
    modulus = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4.m1.err", int'(err), 1);
    chk_all("t4.m1", 0, 0, 0, 0);
    tick();
    chk("t4.m1.err_clr", int'(err), 0);
    modulus = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4.m0.err", int'(err), 1);
    chk_all("t4.m0", 0, 0, 0, 0);
    modulus = 3'd7; n_wraps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4.m7.err", int'(err), 0);
    chk_all("t4.m7.start", 0, 0, 1, 0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_all($sformatf("t4.c%0d", i), i % 7, (i == 7) ? 1 : 0, (i == 7) ? 0 : 1, (i == 7) ? 1 : 0);
    end
    tick();

    // 5: free-run modulus 3 through wrap-counter saturation, start mid-run ignored
    modulus = 3'd3; n_wraps = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    modulus = 3'd7;
    for (int i = 1; i <= 60; i++) begin
      start = (i == 10) ? 1'b1 : 1'b0;
      tick();
      chk_all($sformatf("t5.c%0d", i), i % 3, (i % 3 == 0) ? 1 : 0, 1, 0);
    end
    start = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("t5.stop", 0, 0, 0, 0);

    // 6: asynchronous reset between edges at q=4
    modulus = 3'd5; n_wraps = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6.q4", int'(q), 4);
    #2;
    rst = 1'b0;
    #1;
    chk("t6.async.q", int'(q), 0);
    chk("t6.async.busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(); tick();
    chk_all("t6.idle", 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("t6.restart", 0, 0, 1, 0);
    tick();
    chk_all("t6.count", 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
